instr_cycle_sequencer: RTL and testbench

- Multi-cycle phase sequencer for the 32-bit processor core.
- Steps each instruction through fetch, decode, execute, memory, stack-pointer adjust and writeback.
- Gates the static control levels from the opcode decoder with per-phase enables: PC write, IR write, register write, data-memory request.
- Owns the instruction/data memory handshakes, branch resolution and halt/bus-error handling.

---
 rtl/instr_cycle_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_instr_cycle_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cycle_sequencer.sv
// Multi-cycle phase sequencer for the 32-bit core: walks each instruction through
// FETCH/DECODE/EXEC/SPADJ/MEM/WB and gates the datapath strobes per phase.
module instr_cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CW             = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] opcode_in,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    output logic       imem_req,
    output logic       ir_we,
    output logic       alu_en,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       sp_we,
    output logic       reg_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [2:0] phase,
    output logic       halted,
    output logic       bus_err,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_SPADJ  = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_LOAD, C_STORE, C_BRANCH, C_PUSH, C_POP,
        C_CALL, C_RET, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    localparam logic [1:0]    PC_SEQ    = 2'd0;
    localparam logic [1:0]    PC_TARGET = 2'd1;
    localparam logic [1:0]    PC_DMEM   = 2'd2;
    localparam logic [5:0]    OP_NOP    = 6'b110000;
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_t       state_q;
    logic [5:0]   opcode_q;
    logic [CW-1:0] tmo_cnt_q;
    logic         bus_err_q;
    logic         illegal_q;

    op_class_t    op_class;
    logic         branch_taken;
    logic         tmo_expired;
    logic         mem_write;

    function automatic op_class_t classify(input logic [5:0] op);
        casez (op)
            6'b000???, 6'b001???, 6'b101000: return C_ALU;
            6'b0100?0:                       return C_LOAD;   // LD, LDSP
            6'b0100?1:                       return C_STORE;  // ST, STSP
            6'b0110??:                       return C_BRANCH;
            6'b100000:                       return C_PUSH;
            6'b100001:                       return C_POP;
            6'b100010:                       return C_CALL;
            6'b100011:                       return C_RET;
            6'b110000:                       return C_NOP;
            6'b111000:                       return C_HALT;
            default:                         return C_ILLEGAL;
        endcase
    endfunction

    assign op_class    = classify(opcode_q);
    assign tmo_expired = (tmo_cnt_q == TMO_LAST);
    assign mem_write   = (op_class == C_STORE) || (op_class == C_PUSH) || (op_class == C_CALL);

    // Low opcode bits select the condition: BR, BMI, BPL, BZ.
    always_comb begin
        case (opcode_q[1:0])
            2'b00:   branch_taken = 1'b1;
            2'b01:   branch_taken = flag_n;
            2'b10:   branch_taken = !flag_n;
            default: branch_taken = flag_z;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opcode_q  <= OP_NOP;
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every read in this
            // block sees the pre-edge value; the default clear below is overridden by the
            // increment only in a cycle that is still waiting on an ack.
            tmo_cnt_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        opcode_q <= opcode_in;
                        state_q  <= S_DECODE;
                    end else if (tmo_expired) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CW'(1);
                    end
                end
                S_DECODE: begin
                    if (op_class == C_HALT) begin
                        state_q <= S_HALTED;
                    end else if (op_class == C_ILLEGAL) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_class)
                        C_ALU:                        state_q <= S_WB;
                        C_LOAD, C_STORE, C_POP, C_RET: state_q <= S_MEM;
                        C_PUSH, C_CALL:               state_q <= S_SPADJ;
                        default:                      state_q <= S_FETCH;
                    endcase
                end
                S_SPADJ: begin
                    case (op_class)
                        C_PUSH, C_CALL: state_q <= S_MEM;
                        C_POP:          state_q <= S_WB;
                        default:        state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        case (op_class)
                            C_LOAD:       state_q <= S_WB;
                            C_POP, C_RET: state_q <= S_SPADJ;
                            default:      state_q <= S_FETCH;
                        endcase
                    end else if (tmo_expired) begin
                        bus_err_q <= 1'b1;
                        state_q   <= S_HALTED;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CW'(1);
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                end
                S_HALTED: begin
                    if (start) state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Strobes decode from the registered state and opcode; the ack and flag terms let a
    // strobe land in the same cycle as the handshake or branch test that permits it.
    always_comb begin
        // NOTE: every output is given a default first so no path through the case
        // leaves one unassigned and infers a latch.
        imem_req = 1'b0;
        ir_we    = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        sp_we    = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEQ;
        halted   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (op_class == C_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_TARGET : PC_SEQ;
                end else if (op_class == C_NOP) begin
                    pc_we = 1'b1;
                end
            end
            S_SPADJ: begin
                sp_we = 1'b1;
                if (op_class == C_RET) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_DMEM;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ack && mem_write) begin
                    pc_we  = 1'b1;
                    pc_sel = (op_class == C_CALL) ? PC_TARGET : PC_SEQ;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign phase   = state_q;
    assign bus_err = bus_err_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Self-checking bench for instr_cycle_sequencer: an instruction-level model expands each
// opcode into its expected per-cycle strobe pattern, with randomized waits, flags and noise.
module tb_instr_cycle_sequencer;

    localparam int TMO = 15;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_LD   = 6'b010000, OP_ST   = 6'b010001,
                           OP_LDSP = 6'b010010, OP_STSP = 6'b010011, OP_BR   = 6'b011000,
                           OP_BMI  = 6'b011001, OP_BPL  = 6'b011010, OP_BZ   = 6'b011011,
                           OP_PUSH = 6'b100000, OP_POP  = 6'b100001, OP_CALL = 6'b100010,
                           OP_RET  = 6'b100011, OP_MOVE = 6'b101000, OP_NOP  = 6'b110000,
                           OP_HALT = 6'b111000;

    typedef struct packed {
        logic [2:0] phase;
        logic       imem_req, ir_we, alu_en, dmem_req, dmem_we, sp_we, reg_we, pc_we;
        logic [1:0] pc_sel;
        logic       halted, bus_err, illegal;
    } outv_t;

    typedef struct {
        logic       start, imem_ack, dmem_ack, fn, fz;
        logic [5:0] op;
        outv_t      exp;
    } cyc_t;

    logic       clk, rst_n, start, flag_n, flag_z, imem_ack, dmem_ack;
    logic [5:0] opcode_in;
    logic       imem_req, ir_we, alu_en, dmem_req, dmem_we, sp_we, reg_we, pc_we;
    logic [1:0] pc_sel;
    logic [2:0] phase;
    logic       halted, bus_err, illegal;

    int    n_checks = 0;
    int    n_fails  = 0;
    cyc_t  q[$];
    outv_t exp_q[$];
    outv_t obs_q[$];
    bit    m_bus_err, m_illegal;

    instr_cycle_sequencer #(.TIMEOUT_CYCLES(TMO), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode_in(opcode_in),
        .flag_n(flag_n), .flag_z(flag_z), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .alu_en(alu_en), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .sp_we(sp_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .phase(phase), .halted(halted), .bus_err(bus_err),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outv_t sample();
        return {phase, imem_req, ir_we, alu_en, dmem_req, dmem_we, sp_we, reg_we, pc_we,
                pc_sel, halted, bus_err, illegal};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return (op[5:4] == 2'b00) || (op[5:2] == 4'b0100) ||
               (op >= OP_BR && op <= OP_BZ) || (op >= OP_PUSH && op <= OP_RET) ||
               op == OP_MOVE || op == OP_NOP || op == OP_HALT;
    endfunction

    function automatic outv_t base(input int ph);
        outv_t o = '0;
        o.phase   = 3'(ph);
        o.bus_err = m_bus_err;
        o.illegal = m_illegal;
        return o;
    endfunction

    // Inputs that the phase must ignore are filled with noise.
    function automatic cyc_t rc(input outv_t e);
        cyc_t c;
        c.start    = 1'b0;
        c.imem_ack = 1'($urandom);
        c.dmem_ack = 1'($urandom);
        c.fn       = 1'($urandom);
        c.fz       = 1'($urandom);
        c.op       = 6'($urandom);
        c.exp      = e;
        return c;
    endfunction

    function automatic void push_halted();
        cyc_t c = rc(base(7));
        c.exp.halted = 1'b1;
        q.push_back(c);
    endfunction

    function automatic void push_start(input bit from_halted);
        cyc_t c = rc(base(from_halted ? 7 : 0));
        c.exp.halted = from_halted;
        c.start = 1'b1;
        q.push_back(c);
    endfunction

    function automatic bit model_fetch(input logic [5:0] op, input int iw);
        cyc_t c;
        for (int i = 0; i < iw && i < TMO; i++) begin
            c = rc(base(1)); c.exp.imem_req = 1'b1; c.imem_ack = 1'b0; q.push_back(c);
        end
        if (iw >= TMO) begin
            m_bus_err = 1'b1; push_halted(); return 1'b0;
        end
        c = rc(base(1)); c.exp.imem_req = 1'b1; c.exp.ir_we = 1'b1;
        c.imem_ack = 1'b1; c.op = op; q.push_back(c);
        return 1'b1;
    endfunction

    function automatic bit model_mem(input bit we, input int dw, input bit pcw, input bit sel);
        cyc_t c;
        for (int i = 0; i < dw && i < TMO; i++) begin
            c = rc(base(5)); c.exp.dmem_req = 1'b1; c.exp.dmem_we = we; c.dmem_ack = 1'b0;
            q.push_back(c);
        end
        if (dw >= TMO) begin
            m_bus_err = 1'b1; push_halted(); return 1'b0;
        end
        c = rc(base(5)); c.exp.dmem_req = 1'b1; c.exp.dmem_we = we; c.dmem_ack = 1'b1;
        c.exp.pc_we = pcw; c.exp.pc_sel = sel ? 2'd1 : 2'd0;
        q.push_back(c);
        return 1'b1;
    endfunction

    function automatic void push_spadj(input bit ret);
        cyc_t c = rc(base(4));
        c.exp.sp_we = 1'b1;
        if (ret) begin c.exp.pc_we = 1'b1; c.exp.pc_sel = 2'd2; end
        q.push_back(c);
    endfunction

    function automatic void push_wb();
        cyc_t c = rc(base(6));
        c.exp.reg_we = 1'b1; c.exp.pc_we = 1'b1;
        q.push_back(c);
    endfunction

    // One instruction as the architect describes it: its phase list and strobes.
    function automatic void model_instr(input logic [5:0] op, input int iw, input int dw,
                                        input bit fn, input bit fz);
        cyc_t c;
        bit   taken;
        if (!model_fetch(op, iw)) return;
        q.push_back(rc(base(2)));
        if (op == OP_HALT || !is_legal(op)) begin
            if (op != OP_HALT) m_illegal = 1'b1;
            push_halted();
            return;
        end
        taken = (op == OP_BR) || (op == OP_BMI && fn) || (op == OP_BPL && !fn) ||
                (op == OP_BZ && fz);
        c = rc(base(3)); c.fn = fn; c.fz = fz; c.exp.alu_en = 1'b1;
        if (op == OP_NOP || (op >= OP_BR && op <= OP_BZ)) begin
            c.exp.pc_we = 1'b1; c.exp.pc_sel = taken ? 2'd1 : 2'd0;
        end
        q.push_back(c);
        if (op[5:4] == 2'b00 || op == OP_MOVE) push_wb();
        else if (op == OP_LD || op == OP_LDSP) begin if (model_mem(1'b0, dw, 1'b0, 1'b0)) push_wb(); end
        else if (op == OP_ST || op == OP_STSP) void'(model_mem(1'b1, dw, 1'b1, 1'b0));
        else if (op == OP_PUSH) begin push_spadj(1'b0); void'(model_mem(1'b1, dw, 1'b1, 1'b0)); end
        else if (op == OP_CALL) begin push_spadj(1'b0); void'(model_mem(1'b1, dw, 1'b1, 1'b1)); end
        else if (op == OP_POP) begin
            if (model_mem(1'b0, dw, 1'b0, 1'b0)) begin push_spadj(1'b0); push_wb(); end
        end else if (op == OP_RET) begin
            if (model_mem(1'b0, dw, 1'b0, 1'b0)) push_spadj(1'b1);
        end
    endfunction

    function automatic logic [5:0] rand_legal_op();
        logic [5:0] op;
        for (int k = 0; k < 200; k++) begin
            op = 6'($urandom);
            if (is_legal(op) && op != OP_HALT) return op;
        end
        return OP_NOP;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        flag_n = 1'b0; flag_z = 1'b0; opcode_in = 6'd0;
        m_bus_err = 1'b0; m_illegal = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Plays the queued cycles (limit < 0 plays all) and records what the DUT showed.
    task automatic drive_queue(input int limit);
        cyc_t c;
        int   n = 0;
        exp_q.delete(); obs_q.delete();
        while (q.size() > 0 && (limit < 0 || n < limit)) begin
            c = q.pop_front();
            @(negedge clk);
            start = c.start; imem_ack = c.imem_ack; dmem_ack = c.dmem_ack;
            flag_n = c.fn; flag_z = c.fz; opcode_in = c.op;
            #1;
            exp_q.push_back(c.exp);
            obs_q.push_back(sample());
            n++;
        end
        q.delete();
    endtask

    task automatic test_reset();
        outv_t act;
        rst_n = 1'b0; start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        act = sample();
        n_checks++;
        if (act !== outv_t'('0)) begin
            n_fails++; $display("FAIL reset_hold: got %b expected all zero", act);
        end
        do_reset();
        for (int i = 0; i < 4; i++) q.push_back(rc(base(0)));
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL reset_idle cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_alu_stream();
        int n_reg, n_pc;
        do_reset();
        push_start(1'b0);
        for (int i = 0; i < 3; i++) model_instr(OP_ADD, 0, 0, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++)
            model_instr((i % 2 == 0) ? OP_MOVE : {3'b001, 3'($urandom)}, 0, 0, 1'b0, 1'b0);
        drive_queue(-1);
        n_reg = 0; n_pc = 0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL alu_stream cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            if (i >= 1 && i <= 12) begin
                n_reg += int'(obs_q[i].reg_we);
                n_pc  += int'(obs_q[i].pc_we);
            end
        end
        n_checks++;
        if (n_reg !== 3 || n_pc !== 3) begin
            n_fails++; $display("FAIL alu_pulses: got reg_we=%0d pc_we=%0d expected 3 and 3", n_reg, n_pc);
        end
    endtask

    task automatic test_load_delayed();
        int n_req;
        do_reset();
        push_start(1'b0);
        model_instr(OP_LD, 0, 3, 1'b0, 1'b0);
        model_instr(OP_LDSP, 2, 1, 1'b0, 1'b0);
        model_instr(OP_ST, 1, 2, 1'b0, 1'b0);
        model_instr(OP_STSP, 0, 0, 1'b0, 1'b0);
        drive_queue(-1);
        n_req = 0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL load_store cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            if (i >= 1 && i <= 8) n_req += int'(obs_q[i].dmem_req);
        end
        n_checks++;
        if (n_req !== 4) begin
            n_fails++; $display("FAIL ld_req_len: got %0d dmem_req cycles expected 4", n_req);
        end
    endtask

    task automatic test_branch();
        bit seen_reg;
        do_reset();
        push_start(1'b0);
        model_instr(OP_BZ, 0, 0, 1'b0, 1'b1);
        model_instr(OP_BZ, 0, 0, 1'b1, 1'b0);
        model_instr(OP_BMI, 0, 0, 1'b1, 1'b0);
        model_instr(OP_BMI, 0, 0, 1'b0, 1'b1);
        model_instr(OP_BPL, 1, 0, 1'b0, 1'b0);
        model_instr(OP_BPL, 0, 0, 1'b1, 1'b1);
        model_instr(OP_BR, 0, 0, 1'($urandom), 1'($urandom));
        model_instr(OP_NOP, 0, 0, 1'b1, 1'b1);
        drive_queue(-1);
        seen_reg = 1'b0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL branch cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            seen_reg |= obs_q[i].reg_we;
        end
        n_checks++;
        if (seen_reg !== 1'b0) begin
            n_fails++; $display("FAIL branch_no_regwe: got reg_we=1 expected 0");
        end
    endtask

    task automatic test_stack_ops();
        do_reset();
        push_start(1'b0);
        model_instr(OP_CALL, 0, 0, 1'b0, 1'b0);
        model_instr(OP_RET, 0, 0, 1'b0, 1'b0);
        model_instr(OP_PUSH, 1, 2, 1'b0, 1'b0);
        model_instr(OP_POP, 0, 3, 1'b0, 1'b0);
        model_instr(OP_CALL, 2, 1, 1'b0, 1'b0);
        model_instr(OP_RET, 0, 2, 1'b0, 1'b0);
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL stack cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        push_start(1'b0);
        model_instr(OP_ADD, TMO, 0, 1'b0, 1'b0);
        push_start(1'b1);
        model_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        model_instr(OP_LD, TMO - 1, TMO - 1, 1'b0, 1'b0);
        model_instr(OP_ST, 0, TMO, 1'b0, 1'b0);
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL timeout cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
        do_reset();
        push_start(1'b0);
        model_instr(OP_LD, TMO - 1, TMO - 1, 1'b0, 1'b0);
        model_instr(OP_POP, 0, TMO - 1, 1'b0, 1'b0);
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL ack_at_limit cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] op;
        do_reset();
        push_start(1'b0);
        model_instr(6'b111111, 0, 0, 1'b0, 1'b0);
        push_start(1'b1);
        model_instr(OP_HALT, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            push_start(1'b1);
            op = 6'($urandom);
            for (int t = 0; t < 200 && is_legal(op); t++) op = 6'($urandom);
            model_instr(op, int'($urandom_range(2, 0)), 0, 1'b0, 1'b0);
        end
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL illegal cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        outv_t act;
        do_reset();
        push_start(1'b0);
        model_instr(OP_LD, 0, 100, 1'b0, 1'b0);
        drive_queue(7);
        #2 rst_n = 1'b0;
        #1 act = sample();
        n_checks++;
        if (act !== outv_t'('0)) begin
            n_fails++; $display("FAIL reset_mid_mem: got %b expected all zero", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_bus_err = 1'b0; m_illegal = 1'b0;
        for (int i = 0; i < 3; i++) q.push_back(rc(base(0)));
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL post_reset cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push_start(1'b0);
        for (int k = 0; k < 60; k++)
            model_instr(rand_legal_op(), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                        1'($urandom), 1'($urandom));
        drive_queue(-1);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fails++; $display("FAIL random cyc %0d: got %b expected %b", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i].pc_we && obs_q[i].reg_we && obs_q[i].phase != 3'd6) begin
                n_fails++; $display("FAIL pc_reg_overlap cyc %0d: phase %0d", i, obs_q[i].phase);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_load_delayed();
        test_branch();
        test_stack_ops();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
